alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter IDLE_F, default 5'b11111, opcode driven on alu_f whenever no operation is in flight.
REQ-002 CLK  input  1  clock; all state updates on posedge CLK.
REQ-003 CLR  input  1  reset; asynchronous, active-high.
REQ-004 req0/req1  input  1  operation request from requester 0/1.
REQ-005 a0,b0/a1,b1  input  4  operands of requester 0/1.
REQ-006 f0/f1  input  5  opcode of requester 0/1: 00010 add, 00011 sub, 00100 mul, 00110 div, 01000 AND, 01100 OR, 00000 shl, 10000 shr.
REQ-007 gnt0/gnt1  output  1  one-cycle acceptance pulse to requester 0/1.
REQ-008 done0/done1  output  1  one-cycle completion pulse to requester 0/1.
REQ-009 res  output  8  result {hi nibble, lo nibble}, valid while done0 or done1 is high.
REQ-010 err  output  1  illegal opcode flag, valid while done0 or done1 is high.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 alu_a, alu_b  output  4  operands driven to the shared ALU.
REQ-013 alu_f  output  5  opcode driven to the shared ALU.
REQ-014 alu_v  output  1  ALU half select: 0 = low/primary result, 1 = carry/sign/high/remainder.
REQ-015 alu_y  input  4  registered ALU result, valid one cycle after alu_a/alu_b/alu_f/alu_v are presented.

Function
REQ-016 The FSM SHALL have states IDLE, LO, HI, FIN and RESP.
REQ-017 In IDLE with any reqN high, the block SHALL pulse gntN combinationally in that cycle, latch aN/bN/fN and the requester id, and move to LO (or RESP on an illegal opcode).
REQ-018 Arbitration SHALL be round-robin: with both requests high, the pointer port wins; after any grant the pointer moves to the other port.
REQ-019 With a single request high, that request SHALL be granted regardless of the pointer.
REQ-020 A requester SHALL hold reqN and its operands until gntN; operands after gntN are ignored.
REQ-021 LO: drive the latched a/b/f with alu_v=0; two-pass ops (add, sub, mul, div) -> HI, single-pass ops -> FIN.
REQ-022 HI: drive the latched a/b/f with alu_v=1 and capture alu_y into res[3:0]; next state FIN.
REQ-023 FIN, two-pass: capture alu_y into res[7:4]; single-pass: capture alu_y into res[3:0] and set res[7:4]=0; next state RESP.
REQ-024 RESP: pulse doneN for the latched requester for one cycle, hold res and err, return to IDLE.
REQ-025 Latency from grant cycle to done SHALL be 4 cycles for two-pass ops and 3 cycles for single-pass ops.
REQ-026 An opcode outside REQ-006 SHALL go IDLE -> RESP with no ALU access, err=1 and res=0, done 1 cycle after grant.
REQ-027 In IDLE and RESP, alu_f SHALL be IDLE_F, alu_a=alu_b=0 and alu_v=0.
REQ-028 No new grant SHALL issue while busy; a request held across RESP is granted in the following IDLE cycle.
REQ-029 res and err SHALL be cleared on entry to LO and on an illegal-opcode grant.

Reset
REQ-030 While CLR is high: state=IDLE, pointer=port 0, and gnt0/gnt1, done0/done1, err, busy, res, alu_a, alu_b, alu_v = 0; alu_f = IDLE_F.
REQ-031 A CLR assertion mid-operation SHALL abort the operation with no done pulse; the requester must re-request.

Verification
REQ-032 Port 0 add a=14, b=6 granted at cycle 0 -> done0 at cycle 4, res=8'h14, err=0.
REQ-033 Port 1 sub a=6, b=10 -> res=8'hFC; port 1 mul a=14, b=6 -> res=8'h54; port 0 div a=14, b=6 -> res=8'h22 (remainder 2, quotient 2).
REQ-034 Port 0 AND a=14, b=6 -> done0 3 cycles after grant, res=8'h06; shl a=14 -> res=8'h0C.
REQ-035 req0 and req1 both held high after reset -> grants in order 0, 1, 0, 1; no cycle with both gnts high; each done matches its own port.
REQ-036 Port 1 f=5'b11111 -> done1 1 cycle after grant, err=1, res=0, alu_f stays IDLE_F throughout.
REQ-037 CLR pulsed while in HI -> all outputs reset immediately, no done pulse; a subsequent port 0 request is granted first.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter sequencing operations onto a shared registered ALU.
// Two-pass ops read the primary half, then the high half; illegal opcodes skip the ALU.
//
// state | meaning
// IDLE  | waiting for a request; grant issued combinationally
// LO    | primary half presented to the ALU
// HI    | high half presented, primary result captured
// FIN   | final ALU result captured
// RESP  | done pulse to the owning requester, result held
module alu_arbiter #(
   parameter logic [4:0] IDLE_F = 5'b11111
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       req0,
   input  logic       req1,
   input  logic [3:0] a0,
   input  logic [3:0] b0,
   input  logic [3:0] a1,
   input  logic [3:0] b1,
   input  logic [4:0] f0,
   input  logic [4:0] f1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic [7:0] res,
   output logic       err,
   output logic       busy,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [4:0] alu_f,
   output logic       alu_v,
   input  logic [3:0] alu_y
);

   localparam logic [4:0] OP_ADD = 5'b00010;
   localparam logic [4:0] OP_SUB = 5'b00011;
   localparam logic [4:0] OP_MUL = 5'b00100;
   localparam logic [4:0] OP_DIV = 5'b00110;
   localparam logic [4:0] OP_AND = 5'b01000;
   localparam logic [4:0] OP_OR  = 5'b01100;
   localparam logic [4:0] OP_SHL = 5'b00000;
   localparam logic [4:0] OP_SHR = 5'b10000;

   typedef enum logic [2:0] {IDLE, LO, HI, FIN, RESP} state_t;

   function automatic logic op_legal(input logic [4:0] f);
      case (f)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_SHL, OP_SHR: op_legal = 1'b1;
         default: op_legal = 1'b0;
      endcase
   endfunction

   function automatic logic op_two_pass(input logic [4:0] f);
      op_two_pass = (f == OP_ADD) || (f == OP_SUB) || (f == OP_MUL) || (f == OP_DIV);
   endfunction

   state_t     state_q, state_d;
   logic       ptr_q, ptr_d;
   logic       id_q, id_d;
   logic [3:0] a_q, a_d, b_q, b_d;
   logic [4:0] f_q, f_d;
   logic [7:0] res_q, res_d;
   logic       err_q, err_d;
   logic       done0_q, done0_d, done1_q, done1_d;
   logic       busy_q, busy_d;
   logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [4:0] alu_f_q, alu_f_d;
   logic       alu_v_q, alu_v_d;
   logic       sel0, sel1;
   logic       drive;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      a_d     = a_q;
      b_d     = b_q;
      f_d     = f_q;
      res_d   = res_q;
      err_d   = err_q;
      // the pointer port only matters when both requests collide
      sel1    = (state_q == IDLE) && req1 && (!req0 || ptr_q);
      sel0    = (state_q == IDLE) && req0 && !sel1;
      case (state_q)
         IDLE: begin
            if (sel0 || sel1) begin
               id_d    = sel1;
               ptr_d   = !sel1;
               a_d     = sel1 ? a1 : a0;
               b_d     = sel1 ? b1 : b0;
               f_d     = sel1 ? f1 : f0;
               res_d   = 8'h00;
               err_d   = !op_legal(f_d);
               state_d = op_legal(f_d) ? LO : RESP;
            end
         end
         LO: state_d = op_two_pass(f_q) ? HI : FIN;
         HI: begin
            res_d[3:0] = alu_y;
            state_d    = FIN;
         end
         FIN: begin
            if (op_two_pass(f_q)) res_d[7:4] = alu_y;
            else                  res_d      = {4'h0, alu_y};
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      drive   = (state_d == LO) || (state_d == HI);
      alu_a_d = drive ? a_d : 4'h0;
      alu_b_d = drive ? b_d : 4'h0;
      alu_f_d = drive ? f_d : IDLE_F;
      alu_v_d = (state_d == HI);
      busy_d  = (state_d != IDLE);
      done0_d = (state_d == RESP) && !id_d;
      done1_d = (state_d == RESP) && id_d;
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         id_q    <= 1'b0;
         a_q     <= 4'h0;
         b_q     <= 4'h0;
         f_q     <= IDLE_F;
         res_q   <= 8'h00;
         err_q   <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         busy_q  <= 1'b0;
         alu_a_q <= 4'h0;
         alu_b_q <= 4'h0;
         alu_f_q <= IDLE_F;
         alu_v_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         f_q     <= f_d;
         res_q   <= res_d;
         err_q   <= err_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         busy_q  <= busy_d;
         alu_a_q <= alu_a_d;
         alu_b_q <= alu_b_d;
         alu_f_q <= alu_f_d;
         alu_v_q <= alu_v_d;
      end
   end

   // grants are held off while reset is asserted
   assign gnt0  = sel0 && !CLR;
   assign gnt1  = sel1 && !CLR;
   assign done0 = done0_q;
   assign done1 = done1_q;
   assign res   = res_q;
   assign err   = err_q;
   assign busy  = busy_q;
   assign alu_a = alu_a_q;
   assign alu_b = alu_b_q;
   assign alu_f = alu_f_q;
   assign alu_v = alu_v_q;

endmodule
